// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcode/funct constants and ALU codes for mc_sequencer
package mc_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;
   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
endpackage

// File: rtl/mc_funct_decode.sv
// mc_funct_decode: R-type funct field to ALU control code, with legal flag
//   funct    in  [5:0]  funct field of the latched instruction
//   alu_code out [3:0]  ALU operation select (0000 when illegal)
//   legal    out        funct is one of the supported operations
module mc_funct_decode
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_code,
   output logic       legal
);
   always_comb begin
      alu_code = ALU_AND;
      legal    = 1'b1;
      case (funct)
         F_ADD:   alu_code = ALU_ADD;
         F_SUB:   alu_code = ALU_SUB;
         F_AND:   alu_code = ALU_AND;
         F_OR:    alu_code = ALU_OR;
         F_NOR:   alu_code = ALU_NOR;
         F_SLT:   alu_code = ALU_SLT;
         default: legal    = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer
//   clk, reset (sync, active-high); run level request; instr word at PC; alu_v overflow flag
//   ir_en / pc_en / reg_we strobes; alu_cntl registered ALU select; busy / halted status
//   ill_instr / ovf_trap sticky flags; retired wrapping writeback counter (CNT_W bits)
//   Define MC_OVF_TRAP_EN to trap add/sub overflow in EXECUTE instead of writing back.
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [31:0]      instr,
   input  logic             alu_v,
   output logic             ir_en,
   output logic             pc_en,
   output logic             reg_we,
   output logic [3:0]       alu_cntl,
   output logic             busy,
   output logic             halted,
   output logic             ill_instr,
   output logic             ovf_trap,
   output logic [CNT_W-1:0] retired
);
   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [3:0]       alu_cntl_q, alu_cntl_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [3:0]       dec_code;
   logic             dec_legal;
   logic             unused_bits;

   mc_funct_decode u_dec (.funct(ir_q[5:0]), .alu_code(dec_code), .legal(dec_legal));

`ifdef MC_OVF_TRAP_EN
   logic ovf_q, ovf_d;
   logic trap;
   assign trap        = alu_v && (alu_cntl_q == ALU_ADD || alu_cntl_q == ALU_SUB);
   assign ovf_trap    = ovf_q;
   assign unused_bits = ^ir_q[25:6];
`else
   assign ovf_trap    = 1'b0;
   assign unused_bits = ^{ir_q[25:6], alu_v};
`endif

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      alu_cntl_d = alu_cntl_q;
      ill_d      = ill_q;
      retired_d  = retired_q;
`ifdef MC_OVF_TRAP_EN
      ovf_d      = ovf_q;
`endif
      case (state_q)
         S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ill_d      = ill_q | (ir_q[31:26] != OP_RTYPE) | ~dec_legal;
            alu_cntl_d = ill_d ? alu_cntl_q : dec_code;
            state_d    = ill_d ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            state_d = S_WB;
`ifdef MC_OVF_TRAP_EN
            ovf_d   = ovf_q | trap;
            state_d = trap ? S_HALT : S_WB;
`endif
         end
         S_WB: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ir_q       <= '0;
         alu_cntl_q <= '0;
         ill_q      <= 1'b0;
         retired_q  <= '0;
`ifdef MC_OVF_TRAP_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         alu_cntl_q <= alu_cntl_d;
         ill_q      <= ill_d;
         retired_q  <= retired_d;
`ifdef MC_OVF_TRAP_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   // Strobes are masked by reset so a reset landing in WRITEBACK never writes or advances the PC.
   assign ir_en     = (state_q == S_FETCH) && !reset;
   assign reg_we    = (state_q == S_WB) && !reset;
   assign pc_en     = reg_we;
   assign alu_cntl  = alu_cntl_q;
   assign busy      = !(state_q == S_IDLE || state_q == S_HALT);
   assign halted    = state_q == S_HALT;
   assign ill_instr = ill_q;
   assign retired   = retired_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: table-driven and directed self-checking bench for mc_sequencer
module tb_mc_sequencer;
   localparam logic [31:0] I_ADD = 32'h014B4820;
   localparam logic [31:0] I_SUB = 32'h00221822;

   typedef struct {
      logic        rst, run;
      logic [31:0] ins;
      logic        ir, pc, we;
      logic [3:0]  alu;
      logic        busy, halt, ill;
      logic [15:0] ret;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1, run = 1'b0, alu_v = 1'b0;
   logic [31:0] instr = '0;
   logic        ir_en, pc_en, reg_we, busy, halted, ill_instr, ovf_trap;
   logic [3:0]  alu_cntl;
   logic [15:0] retired;
   logic        ir_en4, pc_en4, reg_we4, busy4, halted4, ill4, ovf4;
   logic [3:0]  alu4;
   logic [3:0]  retired4;
   int          pass_cnt = 0, tot_cnt = 0;
   vec_t        tbl[8];

   always #5 clk = ~clk;

   mc_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_v(alu_v),
      .ir_en(ir_en), .pc_en(pc_en), .reg_we(reg_we), .alu_cntl(alu_cntl), .busy(busy),
      .halted(halted), .ill_instr(ill_instr), .ovf_trap(ovf_trap), .retired(retired)
   );

   mc_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_v(alu_v),
      .ir_en(ir_en4), .pc_en(pc_en4), .reg_we(reg_we4), .alu_cntl(alu4), .busy(busy4),
      .halted(halted4), .ill_instr(ill4), .ovf_trap(ovf4), .retired(retired4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      alu_v = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   function automatic vec_t row(logic rst, logic rn, logic ir, logic pc, logic we, logic [3:0] alu,
                                logic bsy, logic [15:0] ret);
      vec_t v;
      v.rst = rst; v.run = rn; v.ins = I_ADD; v.ir = ir; v.pc = pc; v.we = we;
      v.alu = alu; v.busy = bsy; v.halt = 1'b0; v.ill = 1'b0; v.ret = ret;
      return v;
   endfunction

   initial begin
      logic [5:0] fn[5];
      logic [3:0] code[5];
      fn   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      code = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
      // add $9,$10,$11 from reset; run drops during EXECUTE
      tbl[0] = row(1, 0, 0, 0, 0, 4'b0000, 0, 0);
      tbl[1] = row(0, 1, 0, 0, 0, 4'b0000, 0, 0);
      tbl[2] = row(0, 1, 1, 0, 0, 4'b0000, 1, 0);
      tbl[3] = row(0, 1, 0, 0, 0, 4'b0000, 1, 0);
      tbl[4] = row(0, 0, 0, 0, 0, 4'b0010, 1, 0);
      tbl[5] = row(0, 0, 0, 1, 1, 4'b0010, 1, 0);
      tbl[6] = row(0, 0, 0, 0, 0, 4'b0010, 0, 1);
      tbl[7] = row(0, 0, 0, 0, 0, 4'b0010, 0, 1);
      foreach (tbl[i]) begin
         cyc();
         reset = tbl[i].rst;
         run   = tbl[i].run;
         instr = tbl[i].ins;
         #1;
         chk($sformatf("vec[%0d]", i),
             {5'b0, ir_en, pc_en, reg_we, alu_cntl, busy, halted, ill_instr, ovf_trap, retired},
             {5'b0, tbl[i].ir, tbl[i].pc, tbl[i].we, tbl[i].alu, tbl[i].busy, tbl[i].halt,
              tbl[i].ill, 1'b0, tbl[i].ret});
      end

      // five back-to-back legal R-type instructions; alu_v on and/slt must not trap
      do_reset();
      run = 1'b1;
      for (int k = 0; k < 5; k++) begin
         instr = 32'h00221800 | {26'b0, fn[k]};
         alu_v = (k == 2 || k == 4);
         cyc();
         chk($sformatf("b_fetch%0d", k), {ir_en, pc_en, reg_we}, 3'b100);
         cyc();
         chk($sformatf("b_decode%0d", k), {ir_en, pc_en, reg_we}, 3'b000);
         cyc();
         chk($sformatf("b_exec_alu%0d", k), {ir_en, pc_en, reg_we, alu_cntl}, {3'b000, code[k]});
         cyc();
         chk($sformatf("b_wb%0d", k), {ir_en, pc_en, reg_we}, 3'b011);
         if (k == 4) run = 1'b0;
      end
      alu_v = 1'b0;
      cyc();
      chk("b_retired", retired, 5);
      chk("b_flags", {busy, halted, ill_instr, ovf_trap}, 4'b0000);

      // sub with overflow in EXECUTE
      do_reset();
      run   = 1'b1;
      instr = I_SUB;
      cyc();
      cyc();
      alu_v = 1'b1;
      cyc();
      chk("c_exec_alu", alu_cntl, 4'b0110);
      run = 1'b0;
      cyc();
`ifdef MC_OVF_TRAP_EN
      chk("c_after_exec", {halted, ovf_trap, reg_we, pc_en}, 4'b1100);
`else
      chk("c_after_exec", {halted, ovf_trap, reg_we, pc_en}, 4'b0011);
`endif
      alu_v = 1'b0;
      cyc();
`ifdef MC_OVF_TRAP_EN
      chk("c_final", {halted, ovf_trap, busy, reg_we, retired}, {4'b1100, 16'd0});
`else
      chk("c_final", {halted, ovf_trap, busy, reg_we, retired}, {4'b0000, 16'd1});
`endif

      // illegal opcode (lw) halts after DECODE and stays there
      do_reset();
      run   = 1'b1;
      instr = 32'h8C000000;
      cyc();
      cyc();
      chk("d_decode", {ill_instr, halted, busy}, 3'b001);
      cyc();
      chk("d_halt", {ill_instr, halted, busy, ir_en, pc_en, reg_we}, 6'b110000);
      repeat (3) cyc();
      chk("d_stay", {ill_instr, halted, ir_en, pc_en, reg_we, 11'b0, retired}, {5'b11000, 27'b0});
      do_reset();
      chk("d_reset_clear", {ill_instr, halted, busy}, 3'b000);
      // unsupported funct (addu)
      run   = 1'b1;
      instr = 32'h00221821;
      repeat (3) cyc();
      chk("d_funct_ill", {ill_instr, halted, reg_we}, 3'b110);

      // reset asserted during WRITEBACK
      do_reset();
      run   = 1'b1;
      instr = I_ADD;
      repeat (4) cyc();
      chk("e_wb", {pc_en, reg_we}, 2'b11);
      reset = 1'b1;
      #1;
      chk("e_wb_masked", {ir_en, pc_en, reg_we}, 3'b000);
      cyc();
      chk("e_reset_state",
          {ir_en, pc_en, reg_we, alu_cntl, busy, halted, ill_instr, ovf_trap, retired}, 27'b0);
      reset = 1'b0;
      run   = 1'b0;

      // 17 instructions: 4-bit counter wraps to 1
      do_reset();
      run   = 1'b1;
      instr = I_ADD;
      repeat (68) cyc();
      run = 1'b0;
      cyc();
      chk("f_retired16", retired, 17);
      chk("f_retired4_wrap", retired4, 1);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
